fc_weight_server: RTL
=====================

FC_WEIGHT_SERVER -- requirements
Module: fc_weight_server

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, weight address width.
REQ-002 SHALL have parameter DATA_W, default 64, weight word width (8 x signed int8 lanes).
REQ-003 SHALL have parameter LOAD_W, default 16, load-stream halfword width; DATA_W/LOAD_W = 4 beats per word.
REQ-004 SHALL have parameter N_WORDS, default 256, number of weight words per load.
REQ-005 SHALL have port i_clk, input, 1, single clock; one clock; all logic rising-edge.
REQ-006 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port i_load_start, input, 1, pulse; starts or restarts a load.
REQ-008 SHALL have port i_load_data, input, LOAD_W, load-stream halfword.
REQ-009 SHALL have port i_load_valid, input, 1, load beat valid.
REQ-010 SHALL have port o_load_ready, output, 1, module accepts load beats.
REQ-011 SHALL have port o_load_done, output, 1, one-cycle pulse when the last word is written.
REQ-012 SHALL have port o_weight_ready, output, 1, level; complete weight set held.
REQ-013 SHALL have port i_fc_weight_addr, input, ADDR_W, read address from the FC engine.
REQ-014 SHALL have port o_fc_weight, output, DATA_W, read data.
REQ-015 SHALL have port o_rd_oob, output, 1, one-cycle pulse aligned with o_fc_weight; out-of-range read.

Function
REQ-016 SHALL implement states IDLE, LOAD, READY.
REQ-017 IDLE -> LOAD on i_load_start; LOAD -> READY one cycle after the N_WORDS-th word is written; READY -> LOAD on i_load_start.
REQ-018 i_load_start in LOAD SHALL restart: discard the partial word, reset beat and word counters to 0.
REQ-019 o_load_ready SHALL be 1 exactly when state is LOAD; a beat is accepted when i_load_valid and o_load_ready are both 1.
REQ-020 i_load_valid outside LOAD SHALL be ignored with no state change.
REQ-021 Packing little-endian: accepted beat k (0..3) of a word fills bits [16k+15:16k].
REQ-022 On the 4th accepted beat the packed word SHALL be written at word pointer wr_ptr in the same cycle, and wr_ptr incremented.
REQ-023 On the write of word N_WORDS-1, o_load_done SHALL pulse high the following cycle, together with entry to READY.
REQ-024 o_weight_ready SHALL equal (state == READY); it falls in the cycle after i_load_start.
REQ-025 Read latency SHALL be exactly 1 cycle: o_fc_weight at cycle t+1 reflects i_fc_weight_addr sampled at t.
REQ-026 Read in READY with address < N_WORDS SHALL return the stored word.
REQ-027 Read with address >= N_WORDS SHALL return 0 and pulse o_rd_oob.
REQ-028 Read in IDLE or LOAD SHALL return 0 without o_rd_oob.
REQ-029 Simultaneous read and write to the same word in LOAD is not possible, since reads return 0 there; no bypass logic is required.
REQ-030 i_load_start and a final-beat accept in the same cycle: restart SHALL win; no write occurs and o_load_done does not pulse.

Reset
REQ-031 i_rst SHALL force state IDLE and counters 0, and drive o_load_ready=0, o_load_done=0, o_weight_ready=0, o_fc_weight=0, o_rd_oob=0 on the next edge.
REQ-032 Reset mid-load SHALL abandon the load; RAM contents SHALL NOT be cleared but are unusable until a new load completes.

Structure
REQ-033 Shared package fc_pkg SHALL hold ADDR_W, DATA_W, LOAD_W defaults and the state enumeration.
REQ-034 Storage SHALL be the sub-module fc_weight_ram: a simple dual-port RAM, N_WORDS x DATA_W, with a synchronous write port and a registered read port.
REQ-035 The server SHALL contain the FSM, packer, pointers, and the output zero/oob masking register.

Verification
REQ-036 Reset, then load 1024 halfwords with values 0x0000..0x03FF -> o_load_done pulses once; o_weight_ready=1; address 0 reads 0x0003000200010000 one cycle later.
REQ-037 In READY, read address 255 -> 0x03FF03FE03FD03FC; read address 256 -> 0x0 with o_rd_oob=1 for one cycle.
REQ-038 Load with i_load_valid toggling every other cycle -> same final contents as REQ-036, and o_load_ready stays 1 throughout LOAD.
REQ-039 After 6 beats, assert i_load_start, then reload with 0xA5A5 everywhere -> every address reads 0xA5A5A5A5A5A5A5A5 and o_load_done pulses once.
REQ-040 Assert i_rst at beat 500 -> outputs all 0 next cycle and state IDLE; reads return 0 until a full reload completes.
REQ-041 i_load_start in READY -> o_weight_ready=0 the next cycle, and reads return 0 until the new load completes.

Source files
------------

// File: rtl/fc_pkg.sv
// ============================================================
// fc_pkg : shared widths and state encoding for the FC weight server
// Rev 1.0
// ============================================================
`default_nettype none

package fc_pkg;

  localparam int FC_ADDR_W  = 16;
  localparam int FC_DATA_W  = 64;
  localparam int FC_LOAD_W  = 16;
  localparam int FC_N_WORDS = 256;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fc_weight_ram.sv
// ============================================================
// fc_weight_ram : simple dual-port RAM, sync write, registered read
// Rev 1.0
// ============================================================
`default_nettype none

module fc_weight_ram
  import fc_pkg::*;
#(
  parameter int DATA_W = FC_DATA_W,
  parameter int DEPTH  = FC_N_WORDS,
  parameter int AW     = $clog2(FC_N_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fc_weight_server.sv
// ============================================================
// fc_weight_server : halfword load-stream packer, weight RAM and
// a masked 1-cycle read port for the FC engine
// Rev 1.0
// ============================================================
`default_nettype none

module fc_weight_server
  import fc_pkg::*;
#(
  parameter int ADDR_W  = FC_ADDR_W,
  parameter int DATA_W  = FC_DATA_W,
  parameter int LOAD_W  = FC_LOAD_W,
  parameter int N_WORDS = FC_N_WORDS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_start,
  input  logic [LOAD_W-1:0] i_load_data,
  input  logic              i_load_valid,
  output logic              o_load_ready,
  output logic              o_load_done,
  output logic              o_weight_ready,
  input  logic [ADDR_W-1:0] i_fc_weight_addr,
  output logic [DATA_W-1:0] o_fc_weight,
  output logic              o_rd_oob
);

  localparam int C_BEATS  = DATA_W / LOAD_W;
  localparam int C_BEAT_W = $clog2(C_BEATS);
  localparam int C_PTR_W  = $clog2(N_WORDS);
  localparam logic [ADDR_W:0]   C_N_WORDS   = (ADDR_W+1)'(N_WORDS);
  localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(C_BEATS - 1);
  localparam logic [C_PTR_W-1:0]  C_LAST_WORD = C_PTR_W'(N_WORDS - 1);

  logic [1:0]          r_state;
  logic [C_BEAT_W-1:0] r_beat;
  logic [C_PTR_W-1:0]  r_wr_ptr;
  logic [DATA_W-1:0]   r_pack;
  logic                r_load_done;
  logic                r_rd_en;
  logic                r_rd_oob;

  logic                w_accept;
  logic                w_write;
  logic                w_in_range;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_ram_rdata;

  // A start pulse outranks any beat in the same cycle, including a final one.
  assign w_accept   = (r_state == ST_LOAD) && i_load_valid && !i_load_start;
  assign w_write    = w_accept && (r_beat == C_LAST_BEAT);
  assign w_in_range = {1'b0, i_fc_weight_addr} < C_N_WORDS;

  // The final beat goes straight into the word so it is written this cycle.
  always_comb begin
    w_wdata = r_pack;
    w_wdata[DATA_W-1 -: LOAD_W] = i_load_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_wr_ptr    <= '0;
      r_pack      <= '0;
      r_load_done <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_oob    <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      r_rd_en     <= (r_state == ST_READY) && w_in_range;
      r_rd_oob    <= (r_state == ST_READY) && !w_in_range;
      if (i_load_start) begin
        r_state  <= ST_LOAD;
        r_beat   <= '0;
        r_wr_ptr <= '0;
      end else if (w_accept) begin
        r_pack[r_beat*LOAD_W +: LOAD_W] <= i_load_data;
        r_beat <= r_beat + 1'b1;
        if (w_write) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (r_wr_ptr == C_LAST_WORD) begin
            r_state     <= ST_READY;
            r_load_done <= 1'b1;
          end
        end
      end
    end
  end

  fc_weight_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (N_WORDS),
    .AW     (C_PTR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_write),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (i_fc_weight_addr[C_PTR_W-1:0]),
    .o_rdata (w_ram_rdata)
  );

  assign o_load_ready   = (r_state == ST_LOAD);
  assign o_weight_ready = (r_state == ST_READY);
  assign o_load_done    = r_load_done;
  assign o_fc_weight    = r_rd_en ? w_ram_rdata : '0;
  assign o_rd_oob       = r_rd_oob;

endmodule

`default_nettype wire
